sparse_intersect_mac: RTL and testbench



---
 rtl/sparse_intersect_mac.sv | 139 +++++++++++++
 tb/tb_sparse_intersect_mac.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_intersect_mac.sv
// Sparse dot product: merges two index-sorted (index, value) streams and MACs matching indices.
// Result is valid two cycles after the last pop and is held until accepted; in MERGE a beat is popped only when both streams are valid.
package sparse_mac_pkg;
   localparam int VALUE_W = 8;
   localparam int INDEX_W = 16;

   typedef struct packed {
      logic signed [VALUE_W-1:0] value;
      logic        [INDEX_W-1:0] index;
   } decoder_data_t;
endpackage

module sparse_intersect_mac
   import sparse_mac_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                mac_clk,
   input  logic                mac_rst,
   input  logic                start_i,
   input  logic [CNT_W-1:0]    nnz_a_i,
   input  logic [CNT_W-1:0]    nnz_b_i,
   output logic                busy_o,
   input  logic                a_valid_i,
   output logic                a_ready_o,
   input  decoder_data_t       a_data_i,
   input  logic                b_valid_i,
   output logic                b_ready_o,
   input  decoder_data_t       b_data_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ACC_W-1:0]    result_o,
   output logic [CNT_W-1:0]    match_cnt_o
);

   localparam int PROD_W = 2 * VALUE_W;

   typedef enum logic [2:0] {
      IDLE,
      MERGE,
      DRAIN_A,
      DRAIN_B,
      FLUSH,
      RESULT
   } state_t;

   state_t                    state;
   logic [CNT_W-1:0]          rem_a, rem_b;
   logic [CNT_W-1:0]          rem_a_nxt, rem_b_nxt;
   logic [CNT_W-1:0]          match_cnt;
   logic [ACC_W-1:0]          acc;
   logic signed [PROD_W-1:0]  prod;
   logic signed [PROD_W-1:0]  a_ext, b_ext;
   logic                      prod_vld;
   logic                      both_vld, a_le_b, b_le_a;
   logic                      a_pop, b_pop;

   always_comb begin
      both_vld  = a_valid_i & b_valid_i;
      a_le_b    = (a_data_i.index <= b_data_i.index);
      b_le_a    = (b_data_i.index <= a_data_i.index);
      a_ready_o = ((state == MERGE) & both_vld & a_le_b) | ((state == DRAIN_A) & a_valid_i);
      b_ready_o = ((state == MERGE) & both_vld & b_le_a) | ((state == DRAIN_B) & b_valid_i);
      a_pop     = a_valid_i & a_ready_o;
      b_pop     = b_valid_i & b_ready_o;
      rem_a_nxt = rem_a - CNT_W'(a_pop);
      rem_b_nxt = rem_b - CNT_W'(b_pop);
      a_ext     = PROD_W'(a_data_i.value);
      b_ext     = PROD_W'(b_data_i.value);
   end

   assign busy_o      = (state != IDLE);
   assign result_o    = acc;
   assign match_cnt_o = match_cnt;

   always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
         state          <= IDLE;
         rem_a          <= '0;
         rem_b          <= '0;
         match_cnt      <= '0;
         acc            <= '0;
         prod           <= '0;
         prod_vld       <= 1'b0;
         result_valid_o <= 1'b0;
      end else begin
         prod_vld <= 1'b0;
         // Product registered at the match edge, folded into acc one edge later.
         if (prod_vld) acc <= acc + ACC_W'(prod);
         case (state)
            IDLE: begin
               if (start_i) begin
                  rem_a     <= nnz_a_i;
                  rem_b     <= nnz_b_i;
                  acc       <= '0;
                  match_cnt <= '0;
                  if (nnz_a_i != '0 && nnz_b_i != '0) state <= MERGE;
                  else if (nnz_a_i != '0)              state <= DRAIN_A;
                  else if (nnz_b_i != '0)              state <= DRAIN_B;
                  else                                 state <= FLUSH;
               end
            end
            MERGE: begin
               rem_a <= rem_a_nxt;
               rem_b <= rem_b_nxt;
               if (a_pop && b_pop) begin
                  prod      <= a_ext * b_ext;
                  prod_vld  <= 1'b1;
                  match_cnt <= match_cnt + CNT_W'(1);
               end
               if (rem_a_nxt == '0 && rem_b_nxt == '0) state <= FLUSH;
               else if (rem_a_nxt == '0)               state <= DRAIN_B;
               else if (rem_b_nxt == '0)               state <= DRAIN_A;
            end
            DRAIN_A: begin
               rem_a <= rem_a_nxt;
               if (rem_a_nxt == '0) state <= FLUSH;
            end
            DRAIN_B: begin
               rem_b <= rem_b_nxt;
               if (rem_b_nxt == '0) state <= FLUSH;
            end
            FLUSH: begin
               state          <= RESULT;
               result_valid_o <= 1'b1;
            end
            RESULT: begin
               if (result_ready_i) begin
                  result_valid_o <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sparse_intersect_mac.sv
// Bench for sparse_intersect_mac: table of vector pairs with a result scoreboard,
// plus hand sequences for pop order and asynchronous reset mid-vector.
module tb_sparse_intersect_mac;
   import sparse_mac_pkg::*;

   localparam int ACC_W = 16;
   localparam int CNT_W = 16;

   logic                mac_clk = 1'b0;
   logic                mac_rst;
   logic                start_i;
   logic [CNT_W-1:0]    nnz_a_i, nnz_b_i;
   logic                busy_o;
   logic                a_valid_i, a_ready_o;
   decoder_data_t       a_data_i;
   logic                b_valid_i, b_ready_o;
   decoder_data_t       b_data_i;
   logic                result_valid_o, result_ready_i;
   logic [ACC_W-1:0]    result_o;
   logic [CNT_W-1:0]    match_cnt_o;

   sparse_intersect_mac #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .mac_clk        (mac_clk),
      .mac_rst        (mac_rst),
      .start_i        (start_i),
      .nnz_a_i        (nnz_a_i),
      .nnz_b_i        (nnz_b_i),
      .busy_o         (busy_o),
      .a_valid_i      (a_valid_i),
      .a_ready_o      (a_ready_o),
      .a_data_i       (a_data_i),
      .b_valid_i      (b_valid_i),
      .b_ready_o      (b_ready_o),
      .b_data_i       (b_data_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .match_cnt_o    (match_cnt_o)
   );

   initial forever #5 mac_clk = ~mac_clk;

   typedef struct packed {
      int               na;
      int               nb;
      logic [0:3][15:0] ai;
      logic [0:3][7:0]  av;
      logic [0:3][15:0] bi;
      logic [0:3][7:0]  bv;
      logic [15:0]      exp_res;
      logic [15:0]      exp_cnt;
      int               gap;
      int               hold;
   } vec_t;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] cnt;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   decoder_data_t a_q[$];
   decoder_data_t b_q[$];
   exp_t          exp_q[$];
   int            pop_log[$];
   int            m_rem_a, m_rem_b, gap_pct, rr_hold, rr_cnt;
   bit            rv_seen, vec_done;
   int            rv_cycle, last_pop, stab_err, rule_err;
   logic [15:0]   held_res, held_cnt;
   vec_t          tv[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // A beat stays presented until it is popped; bubbles only appear between beats.
   task automatic drive_streams(input bit fa, input bit fb);
      if (!(a_valid_i && !fa)) begin
         if (a_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            a_valid_i = 1'b1;
            a_data_i  = a_q[0];
         end else a_valid_i = 1'b0;
      end
      if (!(b_valid_i && !fb)) begin
         if (b_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            b_valid_i = 1'b1;
            b_data_i  = b_q[0];
         end else b_valid_i = 1'b0;
      end
      if (result_valid_o) begin
         if (rr_cnt < rr_hold) begin
            rr_cnt++;
            result_ready_i = 1'b0;
         end else result_ready_i = 1'b1;
      end else result_ready_i = (rr_hold == 0);
   endtask

   task automatic step();
      bit   fa, fb, fr;
      exp_t e;
      #4;
      fa = a_valid_i && a_ready_o;
      fb = b_valid_i && b_ready_o;
      fr = result_valid_o && result_ready_i;
      if (start_i && !busy_o) last_pop = cyc;
      if (result_valid_o && (a_ready_o || b_ready_o)) rule_err++;
      if (m_rem_a > 0 && m_rem_b > 0 &&
          ((a_ready_o && !b_valid_i) || (b_ready_o && !a_valid_i))) rule_err++;
      if (result_valid_o) begin
         if (!rv_seen) begin
            rv_seen  = 1'b1;
            rv_cycle = cyc;
            held_res = result_o;
            held_cnt = match_cnt_o;
         end else if (result_o !== held_res || match_cnt_o !== held_cnt) stab_err++;
      end
      if (fa) begin
         void'(a_q.pop_front());
         pop_log.push_back(int'(a_data_i.index));
         m_rem_a--;
         last_pop = cyc;
      end
      if (fb) begin
         void'(b_q.pop_front());
         pop_log.push_back(1000 + int'(b_data_i.index));
         m_rem_b--;
         last_pop = cyc;
      end
      if (fr) begin
         if (exp_q.size() == 0) chk("unexpected_result", 32'(result_o), 32'hFFFF_FFFF);
         else begin
            e = exp_q.pop_front();
            chk("result", 32'(result_o), 32'(e.res));
            chk("match_cnt", 32'(match_cnt_o), 32'(e.cnt));
         end
         vec_done = 1'b1;
         rv_seen  = 1'b0;
         rr_cnt   = 0;
      end
      @(posedge mac_clk);
      cyc++;
      @(negedge mac_clk);
      drive_streams(fa, fb);
   endtask

   task automatic run_vector(input vec_t v);
      decoder_data_t d;
      exp_t          e;
      int            n;
      a_q.delete();
      b_q.delete();
      for (int i = 0; i < v.na; i++) begin
         d.index = v.ai[i];
         d.value = v.av[i];
         a_q.push_back(d);
      end
      for (int i = 0; i < v.nb; i++) begin
         d.index = v.bi[i];
         d.value = v.bv[i];
         b_q.push_back(d);
      end
      m_rem_a  = v.na;
      m_rem_b  = v.nb;
      gap_pct  = v.gap;
      rr_hold  = v.hold;
      rr_cnt   = 0;
      pop_log.delete();
      stab_err = 0;
      rule_err = 0;
      vec_done = 1'b0;
      rv_seen  = 1'b0;
      e.res    = v.exp_res;
      e.cnt    = v.exp_cnt;
      exp_q.push_back(e);
      drive_streams(1'b0, 1'b0);
      nnz_a_i = CNT_W'(v.na);
      nnz_b_i = CNT_W'(v.nb);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("busy_after_start", 32'(busy_o), 32'd1);
      n = 0;
      while (!vec_done && n < 300) begin
         step();
         n++;
      end
      if (!vec_done) begin
         chk("result_timeout", 32'(vec_done), 32'd1);
         exp_q.delete();
      end else begin
         chk("beats_left", 32'(a_q.size() + b_q.size()), 32'd0);
         chk("result_latency", 32'(rv_cycle - last_pop), 32'd2);
         chk("result_stable", 32'(stab_err), 32'd0);
         chk("ready_rules", 32'(rule_err), 32'd0);
      end
   endtask

   initial begin
      int exp_order[4];
      bit order_ok;
      tv[0] = '{na:2, nb:3, ai:{16'd3, 16'd10, 16'd0, 16'd0}, av:{8'd5, 8'd4, 8'd0, 8'd0},
                bi:{16'd3, 16'd7, 16'd10, 16'd0}, bv:{8'd2, 8'd9, 8'hFF, 8'd0},
                exp_res:16'd6, exp_cnt:16'd2, gap:0, hold:0};
      tv[1] = '{na:2, nb:2, ai:{16'd1, 16'd4, 16'd0, 16'd0}, av:{8'd7, 8'd7, 8'd0, 8'd0},
                bi:{16'd2, 16'd5, 16'd0, 16'd0}, bv:{8'd3, 8'd3, 8'd0, 8'd0},
                exp_res:16'd0, exp_cnt:16'd0, gap:0, hold:0};
      tv[2] = '{na:0, nb:2, ai:{16'd0, 16'd0, 16'd0, 16'd0}, av:{8'd0, 8'd0, 8'd0, 8'd0},
                bi:{16'd2, 16'd9, 16'd0, 16'd0}, bv:{8'd3, 8'd1, 8'd0, 8'd0},
                exp_res:16'd0, exp_cnt:16'd0, gap:0, hold:0};
      tv[3] = '{na:0, nb:0, ai:{16'd0, 16'd0, 16'd0, 16'd0}, av:{8'd0, 8'd0, 8'd0, 8'd0},
                bi:{16'd0, 16'd0, 16'd0, 16'd0}, bv:{8'd0, 8'd0, 8'd0, 8'd0},
                exp_res:16'd0, exp_cnt:16'd0, gap:0, hold:0};
      tv[4] = '{na:3, nb:3, ai:{16'd0, 16'd1, 16'd2, 16'd0}, av:{8'h7F, 8'h7F, 8'h7F, 8'd0},
                bi:{16'd0, 16'd1, 16'd2, 16'd0}, bv:{8'h7F, 8'h7F, 8'h7F, 8'd0},
                exp_res:16'hBD03, exp_cnt:16'd3, gap:0, hold:0};
      tv[5] = '{na:4, nb:4, ai:{16'd1, 16'd2, 16'd5, 16'd8}, av:{8'd3, 8'hFE, 8'd6, 8'd1},
                bi:{16'd2, 16'd3, 16'd5, 16'd8}, bv:{8'd4, 8'd7, 8'hFD, 8'd10},
                exp_res:16'hFFF0, exp_cnt:16'd3, gap:40, hold:5};
      tv[6] = '{na:3, nb:1, ai:{16'd0, 16'd6, 16'd7, 16'd0}, av:{8'h80, 8'd2, 8'd3, 8'd0},
                bi:{16'd0, 16'd0, 16'd0, 16'd0}, bv:{8'h80, 8'd0, 8'd0, 8'd0},
                exp_res:16'h4000, exp_cnt:16'd1, gap:0, hold:0};
      tv[7] = tv[0];
      tv[7].gap  = 50;
      tv[7].hold = 3;

      mac_rst        = 1'b1;
      start_i        = 1'b0;
      nnz_a_i        = '0;
      nnz_b_i        = '0;
      a_valid_i      = 1'b0;
      b_valid_i      = 1'b0;
      a_data_i       = '0;
      b_data_i       = '0;
      result_ready_i = 1'b0;
      m_rem_a        = 0;
      m_rem_b        = 0;
      repeat (2) @(negedge mac_clk);
      chk("rst_flags", 32'({a_ready_o, b_ready_o, result_valid_o, busy_o}), 32'd0);
      chk("rst_result", 32'(result_o), 32'd0);
      chk("rst_match", 32'(match_cnt_o), 32'd0);
      mac_rst = 1'b0;
      @(negedge mac_clk);

      for (int i = 0; i < 8; i++) begin
         run_vector(tv[i]);
         if (i == 1) begin
            exp_order = '{1, 1002, 4, 1005};
            order_ok  = (pop_log.size() == 4);
            for (int k = 0; k < 4 && order_ok; k++) order_ok = (pop_log[k] == exp_order[k]);
            chk("disjoint_pop_order", 32'(order_ok), 32'd1);
         end
      end

      // Asynchronous reset in the middle of a MERGE, then a clean rerun.
      a_q.delete();
      b_q.delete();
      for (int i = 0; i < 3; i++) begin
         a_q.push_back('{value: 8'sd5, index: 16'(2 * i)});
         b_q.push_back('{value: 8'sd2, index: 16'(2 * i)});
      end
      m_rem_a = 3;
      m_rem_b = 3;
      gap_pct = 0;
      rr_hold = 0;
      drive_streams(1'b0, 1'b0);
      nnz_a_i = 16'd3;
      nnz_b_i = 16'd3;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (2) step();
      chk("mid_merge_busy", 32'({busy_o, match_cnt_o != 0}), 32'h3);
      #1 mac_rst = 1'b1;
      #1;
      chk("arst_flags", 32'({a_ready_o, b_ready_o, result_valid_o, busy_o}), 32'd0);
      chk("arst_result", 32'(result_o), 32'd0);
      chk("arst_match", 32'(match_cnt_o), 32'd0);
      a_q.delete();
      b_q.delete();
      exp_q.delete();
      m_rem_a   = 0;
      m_rem_b   = 0;
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      repeat (2) @(negedge mac_clk);
      mac_rst = 1'b0;
      @(negedge mac_clk);
      run_vector(tv[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
